// File: rtl/flip_input_conditioner.sv
// Input conditioning for the flip-flop demo: per-channel synchroniser and debounce
// filter for the switches and step button, plus press strobe and press counter.
module flip_input_conditioner #(
  parameter int unsigned N_IN            = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] sw_in,
  input  logic            btn_in,
  output logic [N_IN-1:0] sw_out,
  output logic            btn_level,
  output logic            step_pulse,
  output logic [7:0]      press_count
);

  localparam int unsigned N_CH = N_IN + 1;
  localparam int unsigned BTN  = N_IN;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] accept_c;
  logic            rise_c;

  assign raw = {btn_in, sw_in};

  // One independent synchroniser + debounce filter per channel
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             ch_s1;
    logic             ch_s2;
    logic             ch_stable;
    logic [CNT_W-1:0] ch_cnt;

    assign s2[i]       = ch_s2;
    assign stable[i]   = ch_stable;
    assign accept_c[i] = (ch_s2 != ch_stable) && (ch_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ch_s1     <= 1'b0;
        ch_s2     <= 1'b0;
        ch_stable <= 1'b0;
        ch_cnt    <= '0;
      end else begin
        ch_s1 <= raw[i];
        ch_s2 <= ch_s1;
        if (ch_s2 == ch_stable) begin
          ch_cnt <= '0;
        end else if (ch_cnt == CNT_MAX) begin
          ch_stable <= ch_s2;
          ch_cnt    <= '0;
        end else begin
          ch_cnt <= ch_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign sw_out    = stable[N_IN-1:0];
  assign btn_level = stable[BTN];

  // Press is the edge at which the button's stable level is about to go 0->1
  assign rise_c = accept_c[BTN] & s2[BTN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pulse  <= 1'b0;
      press_count <= 8'd0;
    end else begin
      step_pulse <= rise_c;
      if (rise_c) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_flip_input_conditioner.sv
// Directed bench for flip_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_flip_input_conditioner;

  localparam int unsigned N_IN = 6;
  localparam int unsigned DEB  = 4;
  localparam int unsigned CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_IN-1:0] sw_in;
  logic            btn_in;
  logic [N_IN-1:0] sw_out;
  logic            btn_level;
  logic            step_pulse;
  logic [7:0]      press_count;

  int tests = 0;
  int fails = 0;

  flip_input_conditioner #(
    .N_IN(N_IN), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .btn_in(btn_in),
    .sw_out(sw_out), .btn_level(btn_level),
    .step_pulse(step_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sw_in  = '0;
    btn_in = 1'b0;
    rst    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sw_in  = 6'b111111;
    btn_in = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (sw_out !== 6'd0 || btn_level !== 1'b0 || step_pulse !== 1'b0 || press_count !== 8'd0) begin
        fails++;
        $display("FAIL reset_hold: sw_out=%b btn=%b step=%b cnt=%0d, want all 0",
                 sw_out, btn_level, step_pulse, press_count);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) begin
        tests++;
        if (sw_out !== 6'd0 || btn_level !== 1'b0 || step_pulse !== 1'b0) begin
          fails++;
          $display("FAIL reset_early: edge5 sw_out=%b btn=%b step=%b, want 0",
                   sw_out, btn_level, step_pulse);
        end
      end else if (e == 6) begin
        tests++;
        if (sw_out !== 6'b111111 || btn_level !== 1'b1 || step_pulse !== 1'b1 || press_count !== 8'd1) begin
          fails++;
          $display("FAIL reset_requal: edge6 sw_out=%b btn=%b step=%b cnt=%0d, want 111111/1/1/1",
                   sw_out, btn_level, step_pulse, press_count);
        end
      end else if (e == 7) begin
        tests++;
        if (step_pulse !== 1'b0) begin
          fails++;
          $display("FAIL reset_pulse_width: step=%b at edge7, want 0", step_pulse);
        end
      end
    end
    // Release gives no pulse, then a second press, then async reset assertion
    sw_in  = '0;
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (btn_level !== 1'b0 || sw_out !== 6'd0 || press_count !== 8'd1) begin
      fails++;
      $display("FAIL reset_release: btn=%b sw_out=%b cnt=%0d, want 0/000000/1",
               btn_level, sw_out, press_count);
    end
    btn_in = 1'b1;
    sw_in  = 6'b010101;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (press_count !== 8'd2 || sw_out !== 6'b010101) begin
      fails++;
      $display("FAIL second_press: cnt=%0d sw_out=%b, want 2/010101", press_count, sw_out);
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (sw_out !== 6'd0 || btn_level !== 1'b0 || press_count !== 8'd0 || step_pulse !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: sw_out=%b btn=%b cnt=%0d step=%b, want all 0 before edge",
               sw_out, btn_level, press_count, step_pulse);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int pulses;
    do_reset();
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (step_pulse !== 1'b0 || press_count !== 8'd0) begin
      fails++;
      $display("FAIL press_early: step=%b cnt=%0d at edge k+4, want 0/0", step_pulse, press_count);
    end
    tick();
    tests++;
    if (step_pulse !== 1'b1 || press_count !== 8'd1 || btn_level !== 1'b1) begin
      fails++;
      $display("FAIL press_accept: step=%b cnt=%0d btn=%b at edge k+5, want 1/1/1",
               step_pulse, press_count, btn_level);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    btn_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 0 || press_count !== 8'd1 || btn_level !== 1'b0) begin
      fails++;
      $display("FAIL press_release: extra pulses=%0d cnt=%0d btn=%b, want 0/1/0",
               pulses, press_count, btn_level);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    logic [3:0] pat;
    do_reset();
    pat    = 4'b1010;
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      btn_in = pat[i];
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    btn_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) begin
        tests++;
        if (step_pulse !== 1'b1) begin
          fails++;
          $display("FAIL bounce_pulse: step=%b at edge k+5, want 1", step_pulse);
        end
      end else if (step_pulse === 1'b1) begin
        pulses++;
      end
    end
    tests++;
    if (pulses !== 0 || press_count !== 8'd1) begin
      fails++;
      $display("FAIL bounce_count: stray pulses=%0d cnt=%0d, want 0/1", pulses, press_count);
    end
  endtask

  task automatic test_glitch();
    int bad;
    do_reset();
    bad   = 0;
    sw_in = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sw_out !== 6'd0) bad++;
    end
    sw_in = 6'b000000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sw_out !== 6'd0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL glitch_reject: sw_out nonzero on %0d cycles, want 0", bad);
    end
    // Fresh simultaneous hold on three channels must qualify from scratch
    sw_in = 6'b101001;
    for (int i = 0; i < 5; i++) tick();
    tests++;
    if (sw_out !== 6'd0) begin
      fails++;
      $display("FAIL glitch_no_residue: sw_out=%b at edge k+4, want 000000", sw_out);
    end
    tick();
    tests++;
    if (sw_out !== 6'b101001 || btn_level !== 1'b0 || press_count !== 8'd0) begin
      fails++;
      $display("FAIL multi_channel: sw_out=%b btn=%b cnt=%0d, want 101001/0/0",
               sw_out, btn_level, press_count);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    do_reset();
    pulses = 0;
    for (int p = 0; p < 256; p++) begin
      if (p == 255) begin
        tests++;
        if (press_count !== 8'd255) begin
          fails++;
          $display("FAIL wrap_pre: cnt=%0d before 256th press, want 255", press_count);
        end
      end
      btn_in = 1'b1;
      for (int i = 0; i < 7; i++) begin
        tick();
        if (step_pulse === 1'b1) pulses++;
      end
      btn_in = 1'b0;
      for (int i = 0; i < 7; i++) begin
        tick();
        if (step_pulse === 1'b1) pulses++;
      end
    end
    tests++;
    if (pulses !== 256 || press_count !== 8'd0) begin
      fails++;
      $display("FAIL wrap: pulses=%0d cnt=%0d, want 256/0", pulses, press_count);
    end
  endtask

  task automatic test_mid_reset();
    int pulses;
    do_reset();
    pulses = 0;
    btn_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (step_pulse === 1'b1) pulses++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (pulses !== 0 || press_count !== 8'd0) begin
      fails++;
      $display("FAIL midrst_pre: pulses=%0d cnt=%0d before reset, want 0/0", pulses, press_count);
    end
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) begin
        tests++;
        if (step_pulse !== 1'b1) begin
          fails++;
          $display("FAIL midrst_pulse: step=%b at post-reset edge 6, want 1", step_pulse);
        end
      end else if (step_pulse === 1'b1) begin
        pulses++;
      end
    end
    tests++;
    if (pulses !== 0 || press_count !== 8'd1) begin
      fails++;
      $display("FAIL midrst_count: stray pulses=%0d cnt=%0d, want 0/1", pulses, press_count);
    end
  endtask

  initial begin
    rst    = 1'b1;
    sw_in  = '0;
    btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
